// File: rtl/muldiv_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// muldiv_ctrl
//
// Multi-cycle multiply/divide sequencer for the execute stage. Accepts
// MULT/MULTU/DIV/DIVU with both operands, runs the multiply through a
// fixed-latency counter and the divide as a 32-step restoring iteration,
// stalls the issuing stage while working, then holds the HI/LO pair until
// the downstream stage accepts it. Only one operation is ever in flight.
//
// Parameters
//   MUL_CYCLES    cycles spent in the MUL state (1..8)
// Ports
//   clk           clock, rising edge
//   rst           asynchronous active-high reset
//   start_valid   an instruction (aluop/src_a/src_b) is presented
//   aluop         decoded ALU op; only the four mult/div ops are acted on
//   src_a         rs operand (multiplicand / dividend)
//   src_b         rt operand (multiplier / divisor)
//   flush         kills any in-flight operation, highest priority
//   ready         downstream accepts the held result this cycle
//   stall_req     hold the issuing stage
//   busy          state is not IDLE
//   result_valid  hi/lo are valid and held
//   hi, lo        upper product / remainder, lower product / quotient
// -----------------------------------------------------------------------------
`ifndef ALUOP_MULT
`define ALUOP_MULT  8'h18
`endif
`ifndef ALUOP_MULTU
`define ALUOP_MULTU 8'h19
`endif
`ifndef ALUOP_DIV
`define ALUOP_DIV   8'h1A
`endif
`ifndef ALUOP_DIVU
`define ALUOP_DIVU  8'h1B
`endif

module muldiv_ctrl #(
    parameter int MUL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_valid,
    input  logic [7:0]  aluop,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    input  logic        ready,
    output logic        stall_req,
    output logic        busy,
    output logic        result_valid,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [5:0]  cnt_reg, cnt_next;
    logic [31:0] hi_reg, hi_next;
    logic [31:0] lo_reg, lo_next;
    logic [31:0] op_a_reg, op_a_next;     // multiplicand
    logic [31:0] op_b_reg, op_b_next;     // multiplier or |divisor|
    logic        signed_reg, signed_next; // multiply signedness
    logic        quot_neg_reg, quot_neg_next;
    logic        rem_neg_reg, rem_neg_next;
    logic [31:0] rem_reg, rem_next;
    logic [31:0] quot_reg, quot_next;     // dividend shifts out as quotient shifts in

    // Decode
    logic is_mul_op, is_div_op, is_signed_op, start;
    assign is_mul_op    = (aluop == `ALUOP_MULT) || (aluop == `ALUOP_MULTU);
    assign is_div_op    = (aluop == `ALUOP_DIV)  || (aluop == `ALUOP_DIVU);
    assign is_signed_op = (aluop == `ALUOP_MULT) || (aluop == `ALUOP_DIV);
    assign start        = start_valid && (is_mul_op || is_div_op)
                          && (state_reg == ST_IDLE) && !flush;

    // Divider magnitudes; |0x80000000| is 0x80000000 read as unsigned.
    logic [31:0] abs_a, abs_b;
    assign abs_a = (is_signed_op && src_a[31]) ? (32'd0 - src_a) : src_a;
    assign abs_b = (is_signed_op && src_b[31]) ? (32'd0 - src_b) : src_b;

    // Product: extend both operands to 64 bits so a plain multiply yields
    // the correct low 64 bits for either signedness.
    logic [63:0] mul_ext_a, mul_ext_b, product;
    assign mul_ext_a = signed_reg ? {{32{op_a_reg[31]}}, op_a_reg} : {32'd0, op_a_reg};
    assign mul_ext_b = signed_reg ? {{32{op_b_reg[31]}}, op_b_reg} : {32'd0, op_b_reg};
    assign product   = mul_ext_a * mul_ext_b;

    // One restoring step. The shifted remainder needs 33 bits because it can
    // reach almost twice the divisor; the trial result's top bit is the
    // borrow that says "does not fit".
    logic [32:0] rem_shift, trial;
    logic        take;
    logic [31:0] rem_step, quot_step;
    assign rem_shift = {rem_reg, quot_reg[31]};
    assign trial     = rem_shift - {1'b0, op_b_reg};
    assign take      = !trial[32];
    assign rem_step  = take ? trial[31:0] : rem_shift[31:0];
    assign quot_step = {quot_reg[30:0], take};

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        hi_next       = hi_reg;
        lo_next       = lo_reg;
        op_a_next     = op_a_reg;
        op_b_next     = op_b_reg;
        signed_next   = signed_reg;
        quot_neg_next = quot_neg_reg;
        rem_neg_next  = rem_neg_reg;
        rem_next      = rem_reg;
        quot_next     = quot_reg;

        if (flush) begin
            // Kill everything; hi/lo keep the last delivered result.
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        cnt_next = 6'd0;
                        if (is_mul_op) begin
                            op_a_next   = src_a;
                            op_b_next   = src_b;
                            signed_next = is_signed_op;
                            state_next  = ST_MUL;
                        end else if (src_b == 32'd0) begin
                            hi_next    = src_a;
                            lo_next    = 32'hFFFF_FFFF;
                            state_next = ST_DONE;
                        end else begin
                            quot_next     = abs_a;
                            rem_next      = 32'd0;
                            op_b_next     = abs_b;
                            quot_neg_next = is_signed_op && (src_a[31] ^ src_b[31]);
                            rem_neg_next  = is_signed_op && src_a[31];
                            state_next    = ST_DIV;
                        end
                    end
                end
                ST_MUL: begin
                    cnt_next = cnt_reg + 6'd1;
                    if (cnt_reg == 6'(MUL_CYCLES - 1)) begin
                        {hi_next, lo_next} = product;
                        state_next         = ST_DONE;
                    end
                end
                ST_DIV: begin
                    cnt_next  = cnt_reg + 6'd1;
                    rem_next  = rem_step;
                    quot_next = quot_step;
                    if (cnt_reg == 6'd31) begin
                        lo_next    = quot_neg_reg ? (32'd0 - quot_step) : quot_step;
                        hi_next    = rem_neg_reg  ? (32'd0 - rem_step)  : rem_step;
                        state_next = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (ready) begin
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= 6'd0;
            hi_reg       <= 32'd0;
            lo_reg       <= 32'd0;
            op_a_reg     <= 32'd0;
            op_b_reg     <= 32'd0;
            signed_reg   <= 1'b0;
            quot_neg_reg <= 1'b0;
            rem_neg_reg  <= 1'b0;
            rem_reg      <= 32'd0;
            quot_reg     <= 32'd0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            hi_reg       <= hi_next;
            lo_reg       <= lo_next;
            op_a_reg     <= op_a_next;
            op_b_reg     <= op_b_next;
            signed_reg   <= signed_next;
            quot_neg_reg <= quot_neg_next;
            rem_neg_reg  <= rem_neg_next;
            rem_reg      <= rem_next;
            quot_reg     <= quot_next;
        end
    end

    assign busy         = (state_reg != ST_IDLE);
    assign result_valid = (state_reg == ST_DONE);
    assign stall_req    = start || (state_reg == ST_MUL) || (state_reg == ST_DIV);
    assign hi           = hi_reg;
    assign lo           = lo_reg;

endmodule

// File: tb/tb_muldiv_ctrl.sv
`timescale 1ns/1ps
`ifndef ALUOP_MULT
`define ALUOP_MULT  8'h18
`endif
`ifndef ALUOP_MULTU
`define ALUOP_MULTU 8'h19
`endif
`ifndef ALUOP_DIV
`define ALUOP_DIV   8'h1A
`endif
`ifndef ALUOP_DIVU
`define ALUOP_DIVU  8'h1B
`endif

module tb_muldiv_ctrl;
    localparam int MUL_CYCLES = 2;
    localparam logic [7:0] OP_MULT  = `ALUOP_MULT;
    localparam logic [7:0] OP_MULTU = `ALUOP_MULTU;
    localparam logic [7:0] OP_DIV   = `ALUOP_DIV;
    localparam logic [7:0] OP_DIVU  = `ALUOP_DIVU;

    logic        clk = 1'b0;
    logic        rst, start_valid, flush, ready;
    logic [7:0]  aluop;
    logic [31:0] src_a, src_b;
    logic        stall_req, busy, result_valid;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] last_hilo = 64'd0;

    muldiv_ctrl #(.MUL_CYCLES(MUL_CYCLES)) dut (
        .clk(clk), .rst(rst), .start_valid(start_valid), .aluop(aluop),
        .src_a(src_a), .src_b(src_b), .flush(flush), .ready(ready),
        .stall_req(stall_req), .busy(busy), .result_valid(result_valid),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain arithmetic on 64-bit integers; returns {hi, lo}.
    function automatic logic [63:0] ref_result(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (op == OP_MULT)  return 64'(sa * sb);
        if (op == OP_MULTU) return ua * ub;
        if (b == 32'd0)     return {a, 32'hFFFF_FFFF};
        if (op == OP_DIV) begin
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {32'(ua % ub), 32'(ua / ub)};
    endfunction

    function automatic int ref_latency(input logic [7:0] op, input logic [31:0] b);
        if (op == OP_MULT || op == OP_MULTU) return 1 + MUL_CYCLES;
        if (b == 32'd0) return 1;
        return 33;
    endfunction

    function automatic string op_name(input logic [7:0] op);
        case (op)
            OP_MULT:  return "MULT";
            OP_MULTU: return "MULTU";
            OP_DIV:   return "DIV";
            default:  return "DIVU";
        endcase
    endfunction

    // Present a start in cycle T.
    task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        check_eq("idle_before_start", busy, 1'b0);
        start_valid = 1'b1; aluop = op; src_a = a; src_b = b;
        #1;
        check_eq("start_stall", stall_req, 1'b1);
    endtask

    // From cycle T, scramble the operands and wait for result_valid.
    task automatic wait_done(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        int cycles;
        logic [63:0] exp;
        exp = ref_result(op, a, b);
        @(negedge clk);
        start_valid = 1'b0; aluop = 8'($urandom); src_a = $urandom; src_b = $urandom;
        cycles = 1;
        #1;
        while (!result_valid && cycles < 200) begin
            check_eq("busy_stall_while_working", {busy, stall_req}, 2'b11);
            @(negedge clk);
            cycles++;
            #1;
        end
        check_eq("latency", cycles, ref_latency(op, b));
        check_eq("hilo", {hi, lo}, exp);
        check_eq("done_no_stall", stall_req, 1'b0);
        last_hilo = exp;
        $display("%-5s a=%08h b=%08h -> hi=%08h lo=%08h latency=%0d", op_name(op), a, b, hi, lo, cycles);
    endtask

    // Hold in DONE for 'hold' cycles, optionally presenting a MULT that must be
    // ignored until the cycle after ready.
    task automatic release_result(input int hold, input bit try_start, input logic [31:0] ta, input logic [31:0] tb);
        for (int i = 0; i <= hold; i++) begin
            if (i > 0) @(negedge clk);
            start_valid = try_start; aluop = OP_MULT; src_a = ta; src_b = tb;
            ready = (i == hold);
            #1;
            check_eq("done_hold_flags", {result_valid, busy, stall_req}, 3'b110);
            check_eq("done_hold_hilo", {hi, lo}, last_hilo);
        end
        @(negedge clk);
        ready = 1'b0;
        #1;
        check_eq("idle_after_ready", {busy, result_valid}, 2'b00);
        check_eq("restart_stall", stall_req, try_start);
        if (!try_start) start_valid = 1'b0;
    endtask

    task automatic do_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input bit try_start);
        logic [31:0] ta, tb;
        ta = $urandom; tb = $urandom;
        issue(op, a, b);
        wait_done(op, a, b);
        release_result(hold, try_start, ta, tb);
        if (try_start) begin
            wait_done(OP_MULT, ta, tb);
            release_result(0, 1'b0, 32'd0, 32'd0);
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [7:0] ops [4];
        ops[0] = OP_MULT; ops[1] = OP_MULTU; ops[2] = OP_DIV; ops[3] = OP_DIVU;
        rst = 1'b1; start_valid = 1'b0; flush = 1'b0; ready = 1'b0;
        aluop = 8'd0; src_a = 32'd0; src_b = 32'd0;
        repeat (2) @(negedge clk);
        check_eq("reset_outputs", {busy, result_valid, stall_req, hi, lo}, 67'd0);
        rst = 1'b0;

        // Directed cases
        do_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 0, 1'b0);
        do_op(OP_MULT,  32'hFFFF_FFFF, 32'd2, 1, 1'b0);
        do_op(OP_DIV,   32'hFFFF_FFF9, 32'd2, 0, 1'b0);
        do_op(OP_DIVU,  32'd100,       32'd7, 5, 1'b1);
        do_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        do_op(OP_DIVU,  32'd5,         32'd0, 2, 1'b1);

        // Flush during a divide; a MULTU right after must run normally.
        issue(OP_DIVU, 32'd12345, 32'd17);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            start_valid = 1'b0;
            flush = (i == 10);
        end
        @(negedge clk);
        flush = 1'b0;
        #1;
        check_eq("flush_idle", {busy, result_valid}, 2'b00);
        check_eq("flush_hilo_kept", {hi, lo}, last_hilo);
        start_valid = 1'b1; aluop = OP_MULTU; src_a = 32'h1234_5678; src_b = 32'h9ABC_DEF0;
        #1;
        check_eq("post_flush_start_stall", stall_req, 1'b1);
        wait_done(OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
        release_result(0, 1'b0, 32'd0, 32'd0);

        // Asynchronous reset in the middle of a multiply.
        issue(OP_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        @(negedge clk);
        start_valid = 1'b0;
        #1;
        check_eq("mul_busy", busy, 1'b1);
        #1 rst = 1'b1;
        #1;
        check_eq("async_reset_outputs", {busy, result_valid, stall_req, hi, lo}, 67'd0);
        #1 rst = 1'b0;
        last_hilo = 64'd0;

        // Randomized traffic against the reference model.
        for (int n = 0; n < 40; n++) begin
            do_op(ops[$urandom_range(0, 3)], pick_operand(), pick_operand(),
                  $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Multi-cycle multiply/divide sequencer for the execute stage. It receives MULT/MULTU/DIV/DIVU issued from decode (the aluop plus both operands), runs the multiply through a fixed-latency counter and the divide as a 32-step restoring iteration, and stalls the pipeline until the HI/LO pair is ready. It then holds that result until the downstream stage accepts it for the HI/LO register write. It is the single shared owner of the mult/div resource; only one operation is in flight at a time.

## Interface
- MUL_CYCLES, 2, cycles spent in MUL state (legal range 1..8)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start_valid  in  1  an instruction carrying aluop/src_a/src_b is presented this cycle
- aluop  in  8  decoded ALU op; the block acts only on `ALUOP_MULT, `ALUOP_MULTU, `ALUOP_DIV, `ALUOP_DIVU
- src_a  in  32  rs operand (multiplicand / dividend)
- src_b  in  32  rt operand (multiplier / divisor)
- flush  in  1  exception/branch flush; kills any in-flight operation
- ready  in  1  downstream accepts result this cycle (pipeline not stalled elsewhere)
- stall_req  out  1  hold the issuing stage
- busy  out  1  state is not IDLE
- result_valid  out  1  hi/lo are valid and held
- hi  out  32  HI result (upper product / remainder)
- lo  out  32  LO result (lower product / quotient)

## Operation
- start = start_valid && aluop is one of the four ops && state==IDLE && !flush. Start requests in any other state are ignored; stall_req keeps the issuer frozen until then.
- States: IDLE, MUL, DIV, DONE.
- IDLE on start:
  - MULT/MULTU: latch operands and signedness, clear counter, go to MUL.
  - DIV/DIVU with src_b != 0: latch |a| and |b| (raw values for unsigned), record quotient sign = a[31]^b[31] and remainder sign = a[31] (signed only), clear the 6-bit counter, go to DIV.
  - DIV/DIVU with src_b == 0: hi=src_a, lo=32'hFFFFFFFF, go directly to DONE.
- MUL: counter increments each cycle. When counter==MUL_CYCLES-1, load the 64-bit product (signed or unsigned per the latched op) into {hi,lo} and go to DONE.
- DIV: one restoring step per cycle on a 64-bit shift register {rem,quot}. After step 32 (counter==31), apply the sign fix and go to DONE.
  - Quotient is negated if the quotient sign is set; remainder is negated if the remainder sign is set.
  - Signed 0x80000000 / 0xFFFFFFFF yields lo=0x80000000, hi=0 (natural wrap, no trap).
- DONE: result_valid=1, hi/lo held stable. Move to IDLE on the cycle ready=1; stay otherwise.
- flush in any state: next state is IDLE, result_valid deasserts, and no result is produced. flush has priority over start, ready and completion.
- stall_req = (start) || state==MUL || state==DIV. It is 0 in DONE and in IDLE without a start.
- busy = (state != IDLE).

## Timing
- Reset: state=IDLE, counter=0, hi=0, lo=0, result_valid=0, stall_req=0, busy=0.
- stall_req is combinational from start_valid/aluop in the start cycle T. Registered outputs change on the next edge.
- MUL: result_valid first high in cycle T+1+MUL_CYCLES.
- DIV (nonzero divisor): result_valid first high in cycle T+33.
- Divide by zero: result_valid first high in cycle T+1.
- DONE with ready=1 in cycle D: IDLE in D+1. A new start is accepted in D+1 at the earliest, never in D.
- Reset asserted mid-operation clears everything immediately (asynchronous); the operation is lost.
- Operand inputs may change after cycle T without affecting the result.

## Test plan
- MULTU a=0xFFFFFFFF, b=2, ready=1, MUL_CYCLES=2 -> stall_req high in cycles T..T+2, result_valid in T+3 with hi=0x00000001, lo=0xFFFFFFFE; IDLE at T+4.
- MULT a=0xFFFFFFFF (-1), b=2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (-7), b=2 -> result_valid in T+33, lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 -> lo=14, hi=2.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU a=5, b=0 -> result_valid at T+1, hi=5, lo=0xFFFFFFFF.
- DIVU started, flush at T+10 -> IDLE at T+11, result_valid never asserts, hi/lo unchanged. A new MULTU presented at T+11 completes normally.
- DIVU completes with ready=0 for 5 cycles -> result_valid and hi/lo stay stable, stall_req=0, and a start_valid MULT presented meanwhile is ignored. ready=1 -> IDLE the next cycle, after which that MULT is accepted. Async rst pulse during MUL -> all outputs 0 immediately.
